// File: rtl/data_bus_xfer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | relay_bus_pkg : shared states and register indices for the bus |
// | Revision 1.0                                                   |
// +----------------------------------------------------------------+
package relay_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LOAD  = 2'd2,
    HOLD  = 2'd3
  } xfer_state_e;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_N_SRC  = 9;
  localparam int DEFAULT_N_DST  = 12;

  // Source indices into src_data / src_drive
  localparam int SRC_A   = 0;
  localparam int SRC_B   = 1;
  localparam int SRC_C   = 2;
  localparam int SRC_D   = 3;
  localparam int SRC_M1  = 4;
  localparam int SRC_M2  = 5;
  localparam int SRC_X   = 6;
  localparam int SRC_Y   = 7;
  localparam int SRC_MEM = 8;

  // Destination bit positions in req_dst / dst_load
  localparam int DST_A    = 0;
  localparam int DST_B    = 1;
  localparam int DST_C    = 2;
  localparam int DST_D    = 3;
  localparam int DST_M1   = 4;
  localparam int DST_M2   = 5;
  localparam int DST_X    = 6;
  localparam int DST_Y    = 7;
  localparam int DST_J1   = 8;
  localparam int DST_J2   = 9;
  localparam int DST_INST = 10;
  localparam int DST_MEM  = 11;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_bus_xfer_bus_src_mux.sv
`default_nettype none
// +----------------------------------------------------------------+
// | bus_src_mux : N_SRC:1 bus source select, zero when not enabled |
// | Revision 1.0                                                   |
// +----------------------------------------------------------------+
module bus_src_mux #(
  parameter int DATA_W = 8,
  parameter int N_SRC  = 9,
  parameter int SEL_W  = 4
) (
  input  logic                    i_en,
  input  logic [SEL_W-1:0]        i_sel,
  input  logic [N_SRC*DATA_W-1:0] i_src_data,
  output logic [DATA_W-1:0]       o_data
);

  logic [DATA_W-1:0] w_slice [N_SRC];

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_slice
      assign w_slice[gi] = i_src_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_comb begin
    o_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (i_en && (i_sel == SEL_W'(i))) begin
        o_data = w_slice[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_bus_xfer.sv
`default_nettype none
// +----------------------------------------------------------------+
// | data_bus_xfer : sequenced drive/settle/load/hold bus transfer   |
// | Revision 1.0                                                   |
// +----------------------------------------------------------------+
module data_bus_xfer
  import relay_bus_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int N_SRC      = DEFAULT_N_SRC,
  parameter int N_DST      = DEFAULT_N_DST,
  parameter int SETTLE_CYC = 2,
  parameter int LOAD_CYC   = 1,
  parameter int HOLD_CYC   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [$clog2(N_SRC)-1:0]  req_src,
  input  logic [N_DST-1:0]          req_dst,
  input  logic [N_SRC*DATA_W-1:0]   src_data,
  output logic [N_SRC-1:0]          src_drive,
  output logic [DATA_W-1:0]         bus_data,
  output logic [N_DST-1:0]          dst_load,
  output logic                      xfer_done,
  output logic                      xfer_err
);

  localparam int C_SRC_W = $clog2(N_SRC);
  localparam int C_CNT_W = $clog2(max3(SETTLE_CYC, LOAD_CYC, HOLD_CYC) + 1);
  localparam logic [C_CNT_W-1:0] C_SETTLE_LD = C_CNT_W'(SETTLE_CYC - 1);
  localparam logic [C_CNT_W-1:0] C_LOAD_LD   = C_CNT_W'(LOAD_CYC - 1);
  localparam logic [C_CNT_W-1:0] C_HOLD_LD   = C_CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  xfer_state_e          state_q, state_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic [C_SRC_W-1:0]   src_lat_q, src_lat_d;
  logic [N_DST-1:0]     dst_lat_q, dst_lat_d;
  logic [DATA_W-1:0]    bus_data_q, bus_data_d;
  logic                 xfer_err_q, xfer_err_d;

  logic                 w_accept;
  logic                 w_req_bad;
  logic                 w_busy;
  logic                 w_last;
  logic                 w_mux_en;
  logic [DATA_W-1:0]    w_mux_out;

  assign w_busy    = (state_q != IDLE);
  assign w_accept  = req_valid && (state_q == IDLE);
  assign w_req_bad = (int'(req_src) >= N_SRC) || (req_dst == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    src_lat_d  = src_lat_q;
    dst_lat_d  = dst_lat_q;
    xfer_err_d = 1'b0;
    w_last     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (w_accept) begin
          if (w_req_bad) begin
            xfer_err_d = 1'b1;
          end else begin
            src_lat_d = req_src;
            dst_lat_d = req_dst;
            cnt_d     = C_SETTLE_LD;
            state_d   = DRIVE;
          end
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          cnt_d   = C_LOAD_LD;
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LOAD: begin
        if (cnt_q == '0) begin
          if (HOLD_CYC == 0) begin
            w_last  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d   = C_HOLD_LD;
            state_d = HOLD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          w_last  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The final cycle captures zero so the bus reads idle as soon as the FSM does.
  assign w_mux_en   = w_busy && !w_last;
  assign bus_data_d = w_mux_out;

  bus_src_mux #(
    .DATA_W (DATA_W),
    .N_SRC  (N_SRC),
    .SEL_W  (C_SRC_W)
  ) u_src_mux (
    .i_en       (w_mux_en),
    .i_sel      (src_lat_q),
    .i_src_data (src_data),
    .o_data     (w_mux_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      src_lat_q  <= '0;
      dst_lat_q  <= '0;
      bus_data_q <= '0;
      xfer_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      src_lat_q  <= src_lat_d;
      dst_lat_q  <= dst_lat_d;
      bus_data_q <= bus_data_d;
      xfer_err_q <= xfer_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign src_drive = w_busy ? (N_SRC'(1) << src_lat_q) : '0;
  assign bus_data  = bus_data_q;
  assign dst_load  = (state_q == LOAD) ? dst_lat_q : '0;
  assign xfer_done = w_last;
  assign xfer_err  = xfer_err_q;

`ifndef SYNTHESIS
  a_src_onehot0: assert property (@(posedge clk) disable iff (reset)
    $onehot0(src_drive));
  a_load_only_in_load: assert property (@(posedge clk) disable iff (reset)
    (state_q != LOAD) |-> (dst_load == '0));
  a_idle_quiet: assert property (@(posedge clk) disable iff (reset)
    (state_q == IDLE) |-> !((|dst_load) && (|src_drive)));
`endif

endmodule
`default_nettype wire
